// File: rtl/adc_responder.sv
// Responder end of an LTC2308-style 4-wire serial ADC link: returns on-chip channel data
// to the board ADC controller, with all serial inputs oversampled on the system clock.
module adc_responder #(
   parameter int DATA_BITS   = 12,
   parameter int CFG_BITS    = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     ADC_CS_N,
   input  logic                     ADC_SCLK,
   input  logic                     ADC_DIN,
   output logic                     ADC_DOUT,
   input  logic [8*DATA_BITS-1:0]   ch_data,
   output logic                     sample_strobe,
   output logic [2:0]               cur_channel,
   output logic [15:0]              frame_count
);

   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam int CCW = $clog2(CFG_BITS + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
   localparam logic [CCW-1:0] CFG_FULL = CCW'(CFG_BITS);
   localparam logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(6'b100010);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES:0]   cs_sync, sclk_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [BCW-1:0]         bit_cnt;
   logic [CCW-1:0]         cfg_cnt;
   logic [CFG_BITS-1:0]    cfg_sh, cfg_act;

   // Top bit of each edge-detect chain is the previous value of the synchronized copy.
   wire cs_rise   =  cs_sync[SYNC_STAGES-1]   & ~cs_sync[SYNC_STAGES];
   wire cs_fall   = ~cs_sync[SYNC_STAGES-1]   &  cs_sync[SYNC_STAGES];
   wire sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
   wire sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_sync[SYNC_STAGES];
   wire din_s     = din_sync[SYNC_STAGES-1];

   // Config in force for the conversion happening this cycle (promoted only if complete).
   logic [CFG_BITS-1:0]  next_cfg;
   logic [2:0]           next_ch;
   logic [DATA_BITS-1:0] conv_word;
   logic                 unused_cfg_bits;

   always_comb begin
      next_cfg  = (cfg_cnt == CFG_FULL) ? cfg_sh : cfg_act;
      next_ch   = {next_cfg[3], next_cfg[2], next_cfg[4]};
      conv_word = ch_data[next_ch*DATA_BITS +: DATA_BITS];
      if (!next_cfg[1])
         conv_word[DATA_BITS-1] = ~conv_word[DATA_BITS-1];
   end

   assign unused_cfg_bits = next_cfg[5] ^ next_cfg[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         din_sync  <= '0;
      end else begin
         for (int i = SYNC_STAGES; i > 0; i--) begin
            cs_sync[i]   <= cs_sync[i-1];
            sclk_sync[i] <= sclk_sync[i-1];
         end
         for (int i = SYNC_STAGES-1; i > 0; i--)
            din_sync[i] <= din_sync[i-1];
         cs_sync[0]   <= ADC_CS_N;
         sclk_sync[0] <= ADC_SCLK;
         din_sync[0]  <= ADC_DIN;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         ADC_DOUT      <= 1'b0;
         sample_strobe <= 1'b0;
         cur_channel   <= '0;
         frame_count   <= '0;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         cfg_cnt       <= '0;
         cfg_sh        <= '0;
         cfg_act       <= CFG_RESET;
      end else begin
         sample_strobe <= 1'b0;
         // CS_N edges take priority; an SCLK edge in the same cycle is dropped.
         if (cs_rise) begin
            cfg_act       <= next_cfg;
            shift_reg     <= conv_word;
            cur_channel   <= next_ch;
            sample_strobe <= 1'b1;
            ADC_DOUT      <= 1'b0;
            state         <= IDLE;
         end else if (cs_fall) begin
            ADC_DOUT <= shift_reg[DATA_BITS-1];
            bit_cnt  <= '0;
            cfg_cnt  <= '0;
            state    <= SHIFT;
         end else if (state == SHIFT) begin
            if (sclk_rise && cfg_cnt != CFG_FULL) begin
               cfg_sh  <= {cfg_sh[CFG_BITS-2:0], din_s};
               cfg_cnt <= cfg_cnt + 1'b1;
            end
            if (sclk_fall) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  ADC_DOUT    <= 1'b0;
                  frame_count <= frame_count + 16'd1;
                  state       <= DONE;
               end else begin
                  shift_reg <= {shift_reg[DATA_BITS-2:0], 1'b0};
                  ADC_DOUT  <= shift_reg[DATA_BITS-2];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: drives controller-style frames and checks returned words,
// channel selection, unipolar/bipolar coding, aborts, edge collisions and mid-frame reset.
module tb_adc_responder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ADC_CS_N, ADC_SCLK, ADC_DIN;
   logic        ADC_DOUT;
   logic [95:0] ch_data;
   logic        sample_strobe;
   logic [2:0]  cur_channel;
   logic [15:0] frame_count;

   int n_chk  = 0;
   int n_fail = 0;
   int strobes = 0;
   logic [11:0] w;

   adc_responder dut (
      .clock(clock), .reset_n(reset_n),
      .ADC_CS_N(ADC_CS_N), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT),
      .ch_data(ch_data), .sample_strobe(sample_strobe),
      .cur_channel(cur_channel), .frame_count(frame_count)
   );

   always #10 clock = ~clock;

   always @(negedge clock)
      if (sample_strobe) strobes++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One controller frame: CS_N low, nclk SCLK periods, CS_N high. DOUT sampled just before
   // each SCLK rise; the MSB is sampled SYNC_STAGES+1 clocks after CS_N falls.
   task automatic frame(input logic [5:0] cfg, input int nclk, input bit coincide,
                        input int rst_at, output logic [11:0] word);
      word = '0;
      @(negedge clock); ADC_CS_N = 1'b0;
      repeat (3) @(negedge clock);
      word[11] = ADC_DOUT;
      repeat (5) @(negedge clock);
      for (int i = 0; i < nclk; i++) begin
         ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
         repeat (6) @(negedge clock);
         if (i > 0) word[11-i] = ADC_DOUT;
         if (i == rst_at) begin
            check("dout_before_reset", ADC_DOUT, 1);
            reset_n = 1'b0;
            #1;
            check("dout_in_reset", ADC_DOUT, 0);
            check("fc_in_reset", frame_count, 0);
            check("ch_in_reset", cur_channel, 0);
            ADC_CS_N = 1'b1; ADC_SCLK = 1'b0; ADC_DIN = 1'b0;
            repeat (4) @(negedge clock);
            reset_n = 1'b1;
            repeat (4) @(negedge clock);
            return;
         end
         ADC_SCLK = 1'b1;
         repeat (6) @(negedge clock);
         ADC_SCLK = 1'b0;
      end
      repeat (6) @(negedge clock);
      if (nclk == 12) check("dout_done", ADC_DOUT, 0);
      if (coincide) begin
         ADC_DIN  = cfg[5-nclk];
         ADC_SCLK = 1'b1;
      end
      ADC_CS_N = 1'b1;
      repeat (8) @(negedge clock);
      ADC_SCLK = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0; ADC_CS_N = 1'b1; ADC_SCLK = 1'b0; ADC_DIN = 1'b0; ch_data = '0;
      repeat (4) @(negedge clock);
      check("rst_dout", ADC_DOUT, 0);
      check("rst_strobe", sample_strobe, 0);
      check("rst_ch", cur_channel, 0);
      check("rst_fc", frame_count, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      ch_data[0 +: 12] = 12'hA5C;
      frame(6'b100010, 12, 0, -1, w);  check("f1_word", w, 12'h000);
      check("f1_fc", frame_count, 1);  check("f1_strobes", strobes, 1);
      check("f1_ch", cur_channel, 0);
      frame(6'b100010, 12, 0, -1, w);  check("f2_word", w, 12'hA5C);
      check("f2_fc", frame_count, 2);  check("f2_strobes", strobes, 2);

      ch_data[12 +: 12] = 12'h123;
      ch_data[84 +: 12] = 12'hFFF;
      frame(6'b110010, 12, 0, -1, w);  check("f3_word", w, 12'hA5C);
      check("f3_ch", cur_channel, 1);
      frame(6'b111110, 12, 0, -1, w);  check("f4_word_ch1", w, 12'h123);
      check("f4_ch", cur_channel, 7);
      // CH7 changes after its conversion; the frame in flight must keep 0xFFF.
      ch_data[84 +: 12] = 12'h000;
      ch_data[0 +: 12]  = 12'h800;
      frame(6'b100000, 12, 0, -1, w);  check("f5_word_ch7", w, 12'hFFF);
      check("f5_ch", cur_channel, 0);
      ch_data[0 +: 12] = 12'h7FF;
      frame(6'b100000, 12, 0, -1, w);  check("f6_bipolar_800", w, 12'h000);
      ch_data[0 +: 12] = 12'h3C3;
      frame(6'b100010, 12, 0, -1, w);  check("f7_bipolar_7ff", w, 12'hFFF);

      frame(6'b110010, 3, 0, -1, w);
      check("f8_abort_fc", frame_count, 7);
      check("f8_abort_ch", cur_channel, 0);
      frame(6'b100010, 12, 0, -1, w);  check("f9_after_abort", w, 12'h3C3);
      check("f9_fc", frame_count, 8);  check("f9_strobes", strobes, 9);

      ch_data[84 +: 12] = 12'hFFF;
      frame(6'b111110, 12, 0, -1, w);  check("f10_word", w, 12'h3C3);
      check("f10_fc", frame_count, 9);
      frame(6'b100010, 12, 0, 6, w);
      frame(6'b100010, 12, 0, -1, w);  check("f12_post_reset", w, 12'h000);
      check("f12_fc", frame_count, 1);
      frame(6'b110010, 12, 0, -1, w);  check("f13_ch0", w, 12'h3C3);
      check("f13_ch", cur_channel, 1);

      // Sixth SCLK rise lands in the same cycle as the CS_N rise: config must not complete.
      frame(6'b100010, 5, 1, -1, w);
      check("f14_coincide_ch", cur_channel, 1);
      check("f14_coincide_fc", frame_count, 2);
      frame(6'b100010, 12, 0, -1, w);  check("f15_word", w, 12'h123);
      check("f15_fc", frame_count, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
